framebuffer_reader: RTL

Read-only streaming client of the memory multiplexer's port B. On a start pulse it walks a contiguous byte region of the external SRAM, holds each address on port B long enough to span one complete mux slot rotation, captures the returned byte into a small show-ahead FIFO, and presents the bytes as a valid/ready stream to the pixel/scan-out logic downstream. It runs on the same clock as the memory multiplexer and never writes memory.

---
 rtl/framebuffer_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/framebuffer_reader.sv
// framebuffer_reader: streams a contiguous SRAM byte region through memory-mux port B into a show-ahead FIFO.
// Latency: START edge t -> first capture at t+HOLD_CYCLES; one byte per HOLD_CYCLES clocks sustained.
// Backpressure: fetching pauses (STALL, port B released) while the FIFO is full; PIX_READY drains it.
//
// Ports:
//   FB_CLK, FB_RST_N        clock (shared with the memory mux), async active-low reset
//   START, BUSY, DONE       pass control: start pulse, fetch-in-progress, last-capture pulse
//   PORTB_ADDR/CE/OE/WE     read-only request to mux port B (strobes active-low, WE tied high)
//   PORTB_DATA              byte returned by port B, sampled at the end of each hold window
//   PIX_DATA/VALID/READY    valid/ready byte stream to scan-out
//   LEVEL                   current FIFO occupancy
module framebuffer_reader #(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_BYTES = 19200,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          FB_CLK,
  input  logic                          FB_RST_N,
  input  logic                          START,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [18:0]                   PORTB_ADDR,
  output logic                          PORTB_CE,
  output logic                          PORTB_OE,
  output logic                          PORTB_WE,
  input  logic [7:0]                    PORTB_DATA,
  output logic [7:0]                    PIX_DATA,
  output logic                          PIX_VALID,
  input  logic                          PIX_READY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(HOLD_CYCLES);

  localparam logic [18:0]   BASE      = 19'(BASE_ADDR);
  localparam logic [18:0]   LAST_IDX  = 19'(FRAME_BYTES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] FULL_M1   = LW'(FIFO_DEPTH - 1);

  // Region must be non-empty and stay inside the 19-bit space so the address never wraps.
  if (FRAME_BYTES < 1 || (BASE_ADDR + FRAME_BYTES) > 32'h0008_0000) begin : g_bad_region
    $error("framebuffer_reader: region outside 19-bit address space or empty");
  end
  // One full 4-clock mux rotation plus settle margin is needed before sampling.
  if (HOLD_CYCLES < 5) begin : g_bad_hold
    $error("framebuffer_reader: HOLD_CYCLES must be at least 5");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("framebuffer_reader: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [18:0]     idx_q, idx_d;
  logic [18:0]     addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fetch_q, fetch_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;

  logic            pop;
  logic            push;

  assign pop  = PIX_READY && (level_q != '0);
  assign push = (state_q == S_FETCH) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d  = BASE;
          idx_d   = '0;
          hold_d  = '0;
          state_d = (level_q == DEPTH_L) ? S_STALL : S_FETCH;
        end
      end
      S_FETCH: begin
        if (push) begin
          hold_d = '0;
          if (idx_q == LAST_IDX) begin
            // Address is left on the last byte rather than stepping past the region.
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_q + 19'd1;
            addr_d = addr_q + 19'd1;
            // A pop on the same edge frees the slot this push takes, so keep fetching.
            if (level_q == FULL_M1 && !pop) begin
              state_d = S_STALL;
            end
          end
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      S_STALL: begin
        if (level_q < DEPTH_L) begin
          hold_d  = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    fetch_d = (state_d == S_FETCH);
  end

  always_ff @(posedge FB_CLK or negedge FB_RST_N) begin
    if (!FB_RST_N) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      addr_q  <= BASE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fetch_q <= fetch_d;
    end
  end

  // Show-ahead FIFO: head byte is always visible; a push into an empty FIFO
  // becomes valid on the following cycle (no bypass from PORTB_DATA).
  always_ff @(posedge FB_CLK or negedge FB_RST_N) begin
    if (!FB_RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= PORTB_DATA;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PORTB_ADDR = addr_q;
  assign PORTB_CE   = ~fetch_q;
  assign PORTB_OE   = ~fetch_q;
  assign PORTB_WE   = 1'b1;
  assign PIX_DATA   = mem_q[rd_ptr_q];
  assign PIX_VALID  = (level_q != '0);
  assign LEVEL      = level_q;

endmodule
